// File: rtl/delay_arb_pkg.sv
// Shared definitions for the delay arbiter: FSM state encoding and
// default channel count / delay-limit width.
package delay_arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/delay_timer.sv
// Shared down-counter for the delay arbiter.
// Ports: CLK, RST (sync, active-high), load/value (preset), zero_next
// (high while the count is 1, i.e. the current cycle is the last one).
module delay_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero_next
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_next = (cnt_q == W'(1));

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay timer among NREQ channels.
// Ports: CLK, RST (sync, active-high), req[NREQ], limit[NREQ*W],
// done[NREQ] (one-cycle end pulse), busy, grant_id; optional abort
// input when DELAY_ARB_ABORT_EN is defined.
module delay_arbiter
    import delay_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        limit,
`ifdef DELAY_ARB_ABORT_EN
    input  logic                     abort,
`endif
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int IW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [W-1:0]    lim_q [NREQ];
    logic [W-1:0]    lim_d [NREQ];
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;

    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            any_pend;
    logic [NREQ-1:0] clr;
    logic            abort_i;
    logic            tmr_load;
    logic            tmr_zero_next;
    logic [W-1:0]    cur_lim;
    logic [W-1:0]    tmr_value;

`ifdef DELAY_ARB_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Round-robin pick: scan downward so the closest channel after
    // last_q is the final (winning) assignment.
    always_comb begin
        pick     = last_q;
        idx      = '0;
        any_pend = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % NREQ);
            if (pend_q[idx]) begin
                pick     = idx;
                any_pend = 1'b1;
            end
        end
    end

    // A limit of 0 runs as 1 so RUN always lasts at least one cycle.
    assign cur_lim   = lim_q[grant_q];
    assign tmr_value = (cur_lim == '0) ? W'(1) : cur_lim;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        lim_d    = lim_q;
        grant_d  = grant_q;
        last_d   = last_q;
        tmr_load = 1'b0;
        clr      = '0;

        unique case (state_q)
            IDLE: begin
                if (any_pend) begin
                    grant_d = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                clr[grant_q] = 1'b1;
                if (abort_i) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (tmr_zero_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new request for the channel being cleared in LOAD wins over
        // the clear and captures a fresh limit; the timer still loads
        // from the registered (old) limit.
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (!pend_q[i] || clr[i])) begin
                pend_d[i] = 1'b1;
                lim_d[i]  = limit[i*W +: W];
            end else if (clr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                lim_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            lim_q   <= lim_d;
        end
    end

    delay_timer #(
        .W (W)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (tmr_load),
        .value     (tmr_value),
        .zero_next (tmr_zero_next)
    );

    // Outputs are masked by RST so a reset in DONE emits no pulse.
    always_comb begin
        done = '0;
        if (!RST && (state_q == DONE)) begin
            done[grant_q] = 1'b1;
        end
    end

    assign busy     = !RST && (state_q != IDLE);
    assign grant_id = RST ? '0 : grant_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed self-checking bench for delay_arbiter (NREQ=4, W=8).
// The abort scenario is compiled only with DELAY_ARB_ABORT_EN.
module tb_delay_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] limit;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  grant_id;
`ifdef DELAY_ARB_ABORT_EN
    logic        abort;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    delay_arbiter #(
        .NREQ (4),
        .W    (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .limit    (limit),
`ifdef DELAY_ARB_ABORT_EN
        .abort    (abort),
`endif
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lim(input int ch, input logic [7:0] v);
        limit[ch*8 +: 8] = v;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        req   = '0;
        limit = '0;
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy_async got=%b exp=0", busy);
        if (busy !== 1'b0) failures++;
        step();
        step();
        checks++;
        if (done !== 4'b0000) begin
            $display("FAIL rst_done got=%b exp=0000", done);
            failures++;
        end
        checks++;
        if (grant_id !== 2'd0) begin
            $display("FAIL rst_grant got=%0d exp=0", grant_id);
            failures++;
        end
        RST = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL rst_busy_after got=%b exp=0", busy);
            failures++;
        end
    endtask

    task automatic test_basic();
        logic       exp_b;
        logic [3:0] exp_d;
        do_reset();
        set_lim(0, 8'd5);
        req = 4'b0001;
        step();
        req = '0;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL basic_busy k=0 got=%b exp=0", busy);
            failures++;
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_b = (k >= 1 && k <= 7);
            exp_d = (k == 7) ? 4'b0001 : 4'b0000;
            checks++;
            if (busy !== exp_b) begin
                $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, exp_b);
                failures++;
            end
            checks++;
            if (done !== exp_d) begin
                $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, exp_d);
                failures++;
            end
            if (k == 1) begin
                checks++;
                if (grant_id !== 2'd0) begin
                    $display("FAIL basic_grant got=%0d exp=0", grant_id);
                    failures++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d;
        do_reset();
        for (int c = 0; c < 4; c++) set_lim(c, 8'd2);
        req = 4'b1111;
        step();
        req = '0;
        for (int k = 1; k <= 22; k++) begin
            step();
            exp_d = ((k % 5 == 4) && k <= 19) ? 4'(1 << (k / 5)) : 4'b0000;
            checks++;
            if (done !== exp_d) begin
                $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done, exp_d);
                failures++;
            end
            if (k == 6) begin
                checks++;
                if (grant_id !== 2'd1) begin
                    $display("FAIL b2b_grant got=%0d exp=1", grant_id);
                    failures++;
                end
            end
        end
    endtask

    task automatic test_zero_limit();
        logic [3:0] exp_d;
        do_reset();
        set_lim(1, 8'd0);
        req = 4'b0010;
        step();
        req = '0;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_d = (k == 3) ? 4'b0010 : 4'b0000;
            checks++;
            if (done !== exp_d) begin
                $display("FAIL zero_done k=%0d got=%b exp=%b", k, done, exp_d);
                failures++;
            end
        end
    endtask

    task automatic test_repeat();
        logic [3:0] exp_d;
        do_reset();
        set_lim(2, 8'd3);
        req = 4'b0100;
        step();
        set_lim(2, 8'd9);
        step();
        req = '0;
        for (int k = 2; k <= 12; k++) begin
            step();
            exp_d = (k == 5) ? 4'b0100 : 4'b0000;
            checks++;
            if (done !== exp_d) begin
                $display("FAIL rep_done k=%0d got=%b exp=%b", k, done, exp_d);
                failures++;
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL rep_busy got=%b exp=0", busy);
            failures++;
        end
        set_lim(2, 8'd3);
        req = 4'b0100;
        step();
        req = '0;
        step();
        set_lim(2, 8'd1);
        req = 4'b0100;
        step();
        req = '0;
        for (int k = 3; k <= 12; k++) begin
            step();
            exp_d = (k == 5 || k == 9) ? 4'b0100 : 4'b0000;
            checks++;
            if (done !== exp_d) begin
                $display("FAIL load_req_done k=%0d got=%b exp=%b", k, done, exp_d);
                failures++;
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL load_req_busy got=%b exp=0", busy);
            failures++;
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        do_reset();
        set_lim(0, 8'd20);
        set_lim(3, 8'd2);
        req = 4'b0001;
        step();
        req = '0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) req = 4'b1000;
            step();
            req = '0;
        end
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_busy_pre got=%b exp=1", busy);
            failures++;
        end
        RST = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL mid_busy_rsthi got=%b exp=0", busy);
            failures++;
        end
        step();
        RST = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL mid_busy_post got=%b exp=0", busy);
            failures++;
        end
        bad = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (busy !== 1'b0 || done !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL mid_quiet got=%0d active cycles exp=0", bad);
            failures++;
        end
    endtask

`ifdef DELAY_ARB_ABORT_EN
    task automatic test_abort();
        logic [3:0] exp_d;
        do_reset();
        abort = 1'b0;
        set_lim(1, 8'd10);
        set_lim(3, 8'd2);
        req = 4'b1010;
        step();
        req = '0;
        for (int k = 1; k <= 4; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL abort_busy got=%b exp=0", busy);
            failures++;
        end
        for (int k = 6; k <= 12; k++) begin
            step();
            exp_d = (k == 9) ? 4'b1000 : 4'b0000;
            checks++;
            if (done !== exp_d) begin
                $display("FAIL abort_done k=%0d got=%b exp=%b", k, done, exp_d);
                failures++;
            end
            if (k == 6) begin
                checks++;
                if (busy !== 1'b1 || grant_id !== 2'd3) begin
                    $display("FAIL abort_regrant got=%b/%0d exp=1/3", busy, grant_id);
                    failures++;
                end
            end
        end
    endtask
`endif

    initial begin
`ifdef DELAY_ARB_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_limit();
        test_repeat();
        test_reset_mid_run();
`ifdef DELAY_ARB_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesting channels (2..8).
REQ-002 The block SHALL have parameter W, default 8, delay-limit width in bits.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req  input  NREQ  per-channel delay request; high for one cycle per request.
REQ-006 The block SHALL have port limit  input  NREQ*W  packed per-channel delay in cycles; channel i occupies bits [i*W +: W].
REQ-007 The block SHALL have port done  output  NREQ  per-channel one-cycle pulse marking the end of that channel's delay.
REQ-008 The block SHALL have port busy  output  1  high while the shared timer is allocated.
REQ-009 The block SHALL have port grant_id  output  clog2(NREQ)  index of the channel that owns the timer; valid while busy.

Function
REQ-010 The block SHALL set pending[i] and capture limit[i] into lim_q[i] on any edge where req[i]=1 and pending[i]=0; a req[i] arriving while pending[i]=1 SHALL be ignored, with no capture.
REQ-011 The block SHALL use the FSM states IDLE, LOAD, RUN, DONE.
REQ-012 In IDLE with any pending bit set, the block SHALL grant round-robin, searching from last+1 upward with wrap, record grant_id, and go to LOAD; with none pending it SHALL stay in IDLE.
REQ-013 In LOAD, the block SHALL load the timer with lim_q[grant_id], clear pending[grant_id], and go to RUN; a limit of 0 SHALL be treated as 1.
REQ-014 In RUN, the timer SHALL decrement each cycle; when its value is 1, the block SHALL go to DONE (RUN lasts exactly L cycles).
REQ-015 In DONE, done[grant_id] SHALL be high for exactly one cycle, last SHALL be set to grant_id, and the block SHALL return to IDLE.
REQ-016 With the block idle and no other pending requests, done[i] SHALL rise L+2 edges after the edge that sampled req[i]; back-to-back jobs SHALL cost L+3 cycles each.
REQ-017 busy SHALL be high in LOAD, RUN and DONE, and low in IDLE.
REQ-018 If req[g] for the granted channel arrives in the LOAD cycle, the set SHALL win: the request SHALL be queued anew, and LOAD SHALL use the previously captured lim_q.
REQ-019 Requests arriving during RUN or DONE for any channel SHALL queue per REQ-010 and SHALL NOT disturb the running job.
REQ-020 At most one done bit SHALL be high in any cycle.

Reset
REQ-021 While RST=1, the block SHALL force state=IDLE, pending=0, lim_q=0, timer=0, done=0, busy=0, grant_id=0 and last=NREQ-1, so that channel 0 wins first.
REQ-022 A reset during LOAD/RUN/DONE SHALL drop the job and all pending requests, and SHALL emit no done pulse.

Configuration
REQ-023 With DELAY_ARB_ABORT_EN defined, the block SHALL add the input port abort (1 bit); abort=1 in LOAD or RUN SHALL return the FSM to IDLE on that edge, with no done pulse and last set to grant_id.
REQ-024 Without DELAY_ARB_ABORT_EN, the abort port SHALL be absent and jobs SHALL always run to DONE.

Structure
REQ-025 The shared package delay_arb_pkg SHALL hold the FSM state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3) and the default NREQ/W constants.
REQ-026 The down-counter SHALL be a sub-module delay_timer (ports CLK, RST, load, value, zero_next), instantiated once.

Verification
REQ-027 The bench SHALL cover: reset, then req[0] with limit0=5 sampled at edge 10 -> done[0] high only in the cycle after edge 17; busy high edges 11..18.
REQ-028 The bench SHALL cover: req[0..3] all at the same edge, each limit=2 -> done pulses in order 0,1,2,3, spaced 5 cycles apart.
REQ-029 The bench SHALL cover: limit1=0 -> behaves as 1; done[1] rises 3 edges after req.
REQ-030 The bench SHALL cover: req[2] repeated while pending[2]=1 with a changed limit -> single done[2] after the original delay; req[2] in its own LOAD cycle -> a second job follows.
REQ-031 The bench SHALL cover: RST asserted mid-RUN (limit=20, after 5 cycles) -> no done, busy low the cycle after the reset edge, pending cleared.
REQ-032 The bench SHALL cover, with DELAY_ARB_ABORT_EN: abort during RUN of channel 1 with channel 3 pending -> no done[1]; channel 3 granted on the next IDLE edge.
